// File: rtl/mppc_pkg.sv
// Shared types and default sizing for the MPPC rate-counter and readout blocks.
package mppc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEF_CNT_W       = 12;
  localparam int DEF_WIN_W       = 24;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/mppc_edge_sync.sv
// Brings an asynchronous discriminator line into clk and flags each rising edge.
module mppc_edge_sync
  import mppc_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic hit
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Pulses shorter than a clk period can fall between samples and be missed.
  assign hit = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/mppc_rate_counter.sv
// Gated hit-rate counter: counts synchronised rising edges per window and
// offers each window's count to readout.
module mppc_rate_counter
  import mppc_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WIN_W       = DEF_WIN_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             digital_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] count_out,
  output logic             overflow,
  output logic             dropped,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             dropped_clr,
  output state_t           dbg_state
);

  // Result handshake: a result transfers on any cycle where out_valid and
  // out_ready are both high; while out_valid is high and no transfer occurs,
  // count_out/overflow hold. A window closing onto an unconsumed result is
  // discarded and recorded in dropped.

  state_t             state_q, state_d;
  logic               hit;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [WIN_W-1:0]   win_len_m1;
  logic [CNT_W-1:0]   hit_cnt_q, cnt_nxt;
  logic               ovf_q, ovf_nxt;
  logic               sat;
  logic               close, load, advance, drop_set;

  mppc_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (digital_in),
    .hit  (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = COUNT;
      COUNT:   if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A closing window wins over an abort: enable low on the last cycle still
  // delivers that window's result.
  always_comb begin
    close   = (state_q == COUNT) && (win_cnt_q == '0);
    load    = enable && ((state_q == IDLE) || close);
    advance = enable && (state_q == COUNT) && !close;
  end

  assign win_len_m1 = (window_len == '0) ? '0 : window_len - 1'b1;

  always_comb begin
    sat     = (hit_cnt_q == {CNT_W{1'b1}});
    cnt_nxt = hit_cnt_q;
    ovf_nxt = ovf_q;
    if (hit) begin
      if (sat) ovf_nxt = 1'b1;
      else     cnt_nxt = hit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
      hit_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else if (load) begin
      win_cnt_q <= win_len_m1;
      hit_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else if (advance) begin
      win_cnt_q <= win_cnt_q - 1'b1;
      hit_cnt_q <= cnt_nxt;
      ovf_q     <= ovf_nxt;
    end
  end

  assign drop_set = close && out_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (close && (!out_valid || out_ready)) begin
      count_out <= cnt_nxt;
      overflow  <= ovf_nxt;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           dropped <= 1'b0;
    else if (drop_set)    dropped <= 1'b1;
    else if (dropped_clr) dropped <= 1'b0;
  end

  assign dbg_state = state_q;

endmodule
